// File: rtl/bitonic_sort_stream.sv
// Streaming bitonic sorting network with valid/ready backpressure and per-vector direction.
// Define BITONIC_SORT_STREAM_INDEX_EN to carry input-position tags and expose out_idx.
module bitonic_sort_stream #(
    parameter int VALUE_BITS = 8,
    parameter int DEPTH      = 3
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [(1<<DEPTH)*VALUE_BITS-1:0]           in_data,
    input  logic                                       in_desc,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [(1<<DEPTH)*VALUE_BITS-1:0]           out_data,
    output logic                                       out_desc,
    output logic                                       busy,
    output logic [$clog2(DEPTH*(DEPTH+1)/2+1)-1:0]     inflight
`ifdef BITONIC_SORT_STREAM_INDEX_EN
   ,output logic [(1<<DEPTH)*DEPTH-1:0]                out_idx
`endif
);

    localparam int SIZE = 1 << DEPTH;
    localparam int LAT  = DEPTH * (DEPTH + 1) / 2;
    localparam int CW   = $clog2(LAT + 1);
`ifdef BITONIC_SORT_STREAM_INDEX_EN
    localparam int TAGW = DEPTH;
`else
    localparam int TAGW = 0;
`endif
    localparam int EW   = VALUE_BITS + TAGW;
    localparam int W    = SIZE * EW;

    logic [W-1:0]   inElems;
    logic [W-1:0]   pipeTap     [LAT+1];
    logic [LAT:0]   validTap;
    logic [LAT:0]   descTap;
    logic [W-1:0]   stageData_q [LAT];
    logic [W-1:0]   stageData_d [LAT];
    logic [LAT-1:0] stageValid_q;
    logic [LAT-1:0] stageDesc_q;
    logic [CW-1:0]  inflight_q;
    logic [CW-1:0]  inflight_d;
    logic           advance;
    logic           acceptFire;
    logic           outFire;

    // One compare-exchange column: partner distance 2^j, merge block 2^(s+1).
    // Elements are {key, tag} so a tagged build compares both in the same direction.
    function automatic logic [W-1:0] compareExchange(input logic [W-1:0] v, input int s,
                                                     input int j, input logic desc);
        logic [W-1:0]  r;
        logic [EW-1:0] a;
        logic [EW-1:0] b;
        logic          colDesc;
        int            p;
        r = v;
        for (int i = 0; i < SIZE; i++) begin
            if (((i >> j) & 1) == 0) begin
                p       = i | (1 << j);
                a       = v[i*EW +: EW];
                b       = v[p*EW +: EW];
                colDesc = desc ^ (((i >> (s + 1)) & 1) != 0);
                if (colDesc ? (a < b) : (a > b)) begin
                    r[i*EW +: EW] = b;
                    r[p*EW +: EW] = a;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        inElems = '0;
        for (int i = 0; i < SIZE; i++) begin
`ifdef BITONIC_SORT_STREAM_INDEX_EN
            inElems[i*EW +: EW] = {in_data[i*VALUE_BITS +: VALUE_BITS], DEPTH'(i)};
`else
            inElems[i*EW +: EW] = in_data[i*VALUE_BITS +: VALUE_BITS];
`endif
        end
    end

    // Tap c feeds column c; tap LAT is the output stage.
    always_comb begin
        pipeTap[0]  = inElems;
        validTap[0] = in_valid;
        descTap[0]  = in_desc;
        for (int c = 0; c < LAT; c++) begin
            pipeTap[c+1]  = stageData_q[c];
            validTap[c+1] = stageValid_q[c];
            descTap[c+1]  = stageDesc_q[c];
        end
    end

    always_comb begin
        for (int c = 0; c < LAT; c++) begin
            stageData_d[c] = '0;
        end
        for (int s = 0; s < DEPTH; s++) begin
            for (int k = 0; k <= s; k++) begin
                stageData_d[s*(s+1)/2 + k] = compareExchange(pipeTap[s*(s+1)/2 + k], s, s - k,
                                                             descTap[s*(s+1)/2 + k]);
            end
        end
    end

    assign out_valid  = validTap[LAT];
    assign out_desc   = descTap[LAT];
    assign advance    = !out_valid || out_ready;
    assign in_ready   = advance;
    assign acceptFire = in_valid && advance;
    assign outFire    = out_valid && out_ready;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < SIZE; i++) begin
            out_data[i*VALUE_BITS +: VALUE_BITS] = pipeTap[LAT][i*EW + TAGW +: VALUE_BITS];
        end
    end

`ifdef BITONIC_SORT_STREAM_INDEX_EN
    always_comb begin
        out_idx = '0;
        for (int i = 0; i < SIZE; i++) begin
            out_idx[i*DEPTH +: DEPTH] = pipeTap[LAT][i*EW +: DEPTH];
        end
    end
`endif

    // Whole pipe moves as one; a stalled output freezes every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < LAT; c++) begin
                stageData_q[c] <= '0;
            end
            stageValid_q <= '0;
            stageDesc_q  <= '0;
        end else if (advance) begin
            for (int c = 0; c < LAT; c++) begin
                stageData_q[c]  <= stageData_d[c];
                stageValid_q[c] <= validTap[c];
                stageDesc_q[c]  <= descTap[c];
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({acceptFire, outFire})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;
    assign busy     = (inflight_q != '0);

endmodule

// File: tb/tb_bitonic_sort_stream.sv
// Self-checking bench for bitonic_sort_stream: table vectors, hand sequences, and a
// scoreboard fed by a plain sort-based reference model.
module tb_bitonic_sort_stream;

    localparam int VB    = 8;
    localparam int DEPTH = 3;
    localparam int SIZE  = 8;
    localparam int LAT   = 6;
    localparam int W     = SIZE * VB;
    localparam int IW    = SIZE * DEPTH;
    localparam int CW    = $clog2(LAT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_desc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_desc;
    logic          busy;
    logic [CW-1:0] inflight;
`ifdef BITONIC_SORT_STREAM_INDEX_EN
    logic [IW-1:0] out_idx;
`endif

    bitonic_sort_stream #(.VALUE_BITS(VB), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_desc  (out_desc),
        .busy      (busy),
        .inflight  (inflight)
`ifdef BITONIC_SORT_STREAM_INDEX_EN
       ,.out_idx   (out_idx)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0]  data;
        logic          desc;
        logic [IW-1:0] idx;
    } vec_t;

    typedef struct {
        string         name;
        logic [W-1:0]  data;
        logic          desc;
        logic [W-1:0]  expData;
        logic [IW-1:0] expIdx;
    } tvec_t;

    vec_t        expQ[$];
    tvec_t       vecTable[6];
    int          accCount    = 0;
    int          delCount    = 0;
    int          maxInflight = 0;
    logic        prevStall   = 1'b0;
    logic [W-1:0] prevData   = '0;
    logic        prevDesc    = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [IW-1:0] pkIdx(input logic [2:0] i0, i1, i2, i3, i4, i5, i6, i7);
        return {i7, i6, i5, i4, i3, i2, i1, i0};
    endfunction

    // Reference: sort key*SIZE+position, so ties resolve by position in the same direction.
    function automatic vec_t refSort(input logic [W-1:0] d, input logic desc);
        int   v[SIZE];
        int   t;
        vec_t r;
        for (int i = 0; i < SIZE; i++) v[i] = int'(d[i*VB +: VB]) * SIZE + i;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE - 1 - i; j++) begin
                if (desc ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        r.data = '0;
        r.idx  = '0;
        r.desc = desc;
        for (int i = 0; i < SIZE; i++) begin
            r.data[i*VB +: VB]       = 8'(v[i] / SIZE);
            r.idx[i*DEPTH +: DEPTH]  = 3'(v[i] % SIZE);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] randVec();
        logic [W-1:0] d;
        d = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) d &= 64'h0303030303030303;
        return d;
    endfunction

    // One cycle of streaming: drive, check protocol and scoreboard, then cross one edge.
    task automatic applyStimulus(input logic iv, input logic [W-1:0] d, input logic ds, input logic ordy);
        vec_t e;
        in_valid  = iv;
        in_data   = d;
        in_desc   = ds;
        out_ready = ordy;
        #1;
        checkOutput("in_ready", in_ready, !(out_valid && !ordy));
        checkOutput("inflight", inflight, expQ.size());
        checkOutput("inflight_le_lat", inflight <= LAT, 1);
        checkOutput("busy", busy, expQ.size() != 0);
        if (int'(inflight) > maxInflight) maxInflight = int'(inflight);
        if (prevStall) begin
            checkOutput("stall_data", out_data, prevData);
            checkOutput("stall_desc", out_desc, prevDesc);
        end
        if (out_valid && ordy) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", out_valid, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("out_data", out_data, e.data);
                checkOutput("out_desc", out_desc, e.desc);
`ifdef BITONIC_SORT_STREAM_INDEX_EN
                checkOutput("out_idx", out_idx, e.idx);
`endif
                delCount++;
            end
        end
        if (iv && in_ready) begin
            expQ.push_back(refSort(d, ds));
            accCount++;
        end
        prevStall = out_valid && !ordy;
        prevData  = out_data;
        prevDesc  = out_desc;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("drain_empty", expQ.size(), 0);
    endtask

    initial begin
        int           waits;
        int           accStart;
        int           delStart;
        int           cyc;
        logic [W-1:0] d;

        vecTable[0] = '{"asc_basic", pk(8'hD3,8'h7A,8'h42,8'hBE,8'h11,8'hC4,8'h6F,8'h95), 1'b0,
                        pk(8'h11,8'h42,8'h6F,8'h7A,8'h95,8'hBE,8'hC4,8'hD3), pkIdx(4,2,6,1,7,3,5,0)};
        vecTable[1] = '{"desc_basic", pk(8'hD3,8'h7A,8'h42,8'hBE,8'h11,8'hC4,8'h6F,8'h95), 1'b1,
                        pk(8'hD3,8'hC4,8'hBE,8'h95,8'h7A,8'h6F,8'h42,8'h11), pkIdx(0,5,3,7,1,6,2,4)};
        vecTable[2] = '{"asc_dups", pk(8'h00,8'hFF,8'h00,8'hFF,8'h80,8'h80,8'h00,8'hFF), 1'b0,
                        pk(8'h00,8'h00,8'h00,8'h80,8'h80,8'hFF,8'hFF,8'hFF), pkIdx(0,2,6,4,5,1,3,7)};
        vecTable[3] = '{"desc_dups", pk(8'h00,8'hFF,8'h00,8'hFF,8'h80,8'h80,8'h00,8'hFF), 1'b1,
                        pk(8'hFF,8'hFF,8'hFF,8'h80,8'h80,8'h00,8'h00,8'h00), pkIdx(7,3,1,5,4,6,2,0)};
        vecTable[4] = '{"asc_reversed", pk(8'h08,8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01), 1'b0,
                        pk(8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08), pkIdx(7,6,5,4,3,2,1,0)};
        vecTable[5] = '{"desc_all_equal", pk(8'h5A,8'h5A,8'h5A,8'h5A,8'h5A,8'h5A,8'h5A,8'h5A), 1'b1,
                        pk(8'h5A,8'h5A,8'h5A,8'h5A,8'h5A,8'h5A,8'h5A,8'h5A), pkIdx(7,6,5,4,3,2,1,0)};

        // Reset state while reset is held.
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_desc   = 1'b0;
        out_ready = 1'b1;
        #12;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_desc", out_desc, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_inflight", inflight, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // Table vectors, one at a time into an empty pipe, with latency check.
        for (int t = 0; t < 6; t++) begin
            in_valid  = 1'b1;
            in_data   = vecTable[t].data;
            in_desc   = vecTable[t].desc;
            out_ready = 1'b1;
            #1;
            checkOutput({vecTable[t].name, "_accept"}, in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            waits    = 0;
            while (!out_valid && waits < 20) begin
                @(posedge clk);
                #1;
                waits++;
            end
            checkOutput({vecTable[t].name, "_latency"}, waits, LAT - 1);
            checkOutput({vecTable[t].name, "_data"}, out_data, vecTable[t].expData);
            checkOutput({vecTable[t].name, "_desc"}, out_desc, vecTable[t].desc);
`ifdef BITONIC_SORT_STREAM_INDEX_EN
            checkOutput({vecTable[t].name, "_idx"}, out_idx, vecTable[t].expIdx);
`endif
            @(posedge clk);
            #1;
            checkOutput({vecTable[t].name, "_drained"}, out_valid, 0);
        end

        // Back-to-back vectors with opposite direction emerge on consecutive cycles.
        in_valid = 1'b1;
        in_data  = vecTable[0].data;
        in_desc  = 1'b0;
        @(posedge clk);
        #1;
        in_desc = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waits    = 0;
        while (!out_valid && waits < 20) begin
            @(posedge clk);
            #1;
            waits++;
        end
        checkOutput("dir_a_data", out_data, vecTable[0].expData);
        checkOutput("dir_a_desc", out_desc, 0);
        @(posedge clk);
        #1;
        checkOutput("dir_b_valid", out_valid, 1);
        checkOutput("dir_b_data", out_data, vecTable[1].expData);
        checkOutput("dir_b_desc", out_desc, 1);
        @(posedge clk);
        #1;
        checkOutput("dir_drained", out_valid, 0);

        // Backpressure: 10 vectors, consumer stalls for 4 cycles once the pipe is full.
        accStart    = accCount;
        delStart    = delCount;
        maxInflight = 0;
        cyc         = 0;
        while (accCount - accStart < 10 && cyc < 100) begin
            applyStimulus(1'b1, randVec(), 1'($urandom_range(0, 1)), !(cyc >= 8 && cyc < 12));
            cyc++;
        end
        drain();
        checkOutput("bp_peak_inflight", maxInflight, LAT);
        checkOutput("bp_delivered", delCount - delStart, 10);

        // Reset with four vectors in flight discards them all.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, randVec(), 1'b0, 1'b1);
        in_valid = 1'b0;
        checkOutput("mid_inflight_before", inflight, 4);
        rst = 1'b1;
        #1;
        checkOutput("mid_out_valid", out_valid, 0);
        checkOutput("mid_inflight", inflight, 0);
        checkOutput("mid_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        prevStall = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, vecTable[4].data, 1'b0, 1'b1);
        drain();

        // Random soak with random valid and ready.
        accStart = accCount;
        delStart = delCount;
        cyc      = 0;
        while (accCount - accStart < 1000 && cyc < 20000) begin
            d = randVec();
            applyStimulus(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc++;
        end
        drain();
        checkOutput("soak_accepted", accCount - accStart, 1000);
        checkOutput("soak_delivered", delCount - delStart, accCount - accStart);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
